// File: rtl/sdram_client_port.sv
// sdram_client_port: user-side requester for the SDRAM controller FIFOs.
// Requests are split into single-word and burst command enqueues; a 1-bit
// tag FIFO remembers the kind of each outstanding read so that responses
// are returned in issue order, regardless of which data FIFO fills first.
module sdram_client_port #(
  parameter int TAG_AW = 4
) (
  input  logic         clk,
  input  logic         rst_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic         req_we_i,
  input  logic         req_burst_i,
  input  logic [23:0]  req_addr_i,
  input  logic [15:0]  req_data_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic         rsp_burst_o,
  output logic [15:0]  rsp_data_o,
  output logic [127:0] rsp_burst_data_o,
  output logic         err_o,
  output logic [40:0]  cmd_d_o,
  output logic         cmd_enq_o,
  input  logic         cmd_full_i,
  output logic [31:0]  bcmd_d_o,
  output logic         bcmd_enq_o,
  input  logic         bcmd_full_i,
  input  logic [15:0]  rd_q_i,
  input  logic         rd_empty_i,
  output logic         rd_deq_o,
  input  logic [127:0] rdb_q_i,
  input  logic         rdb_empty_i,
  output logic         rdb_deq_o
);

  localparam int DEPTH = 1 << TAG_AW;

  typedef enum logic {IDLE, GAP} state_t;

  state_t            state_reg;
  logic [TAG_AW:0]   wr_ptr_reg;
  logic [TAG_AW:0]   rd_ptr_reg;
  logic              tag_mem [DEPTH];
  logic              err_pend_reg;
  logic              err_reg;

  logic [TAG_AW:0]   tag_count;
  logic              tag_full;
  logic              tag_empty;
  logic              tag_head;
  logic              burst_rd;
  logic              accept;
  logic              tag_push;
  logic              tag_pop;
  logic              stray_data;

  // Pointer difference carries one extra bit so full and empty are distinct.
  assign tag_count = wr_ptr_reg - rd_ptr_reg;
  assign tag_full  = tag_count[TAG_AW];
  assign tag_empty = (wr_ptr_reg == rd_ptr_reg);
  assign tag_head  = tag_mem[rd_ptr_reg[TAG_AW-1:0]];

  // Request side is fully combinational: each request kind checks only the
  // resources it actually consumes. Reset holds the port closed.
  assign burst_rd = !req_we_i && req_burst_i;

  always_comb begin
    req_ready_o = 1'b0;
    if (!rst_i) begin
      if (req_we_i)
        req_ready_o = !cmd_full_i;
      else if (req_burst_i)
        req_ready_o = !bcmd_full_i && !tag_full;
      else
        req_ready_o = !cmd_full_i && !tag_full;
    end
  end

  assign accept     = req_valid_i && req_ready_o;
  assign cmd_enq_o  = accept && !burst_rd;
  assign bcmd_enq_o = accept && burst_rd;
  assign tag_push   = accept && !req_we_i;

  // Command words always reflect the request inputs; the enq strobes qualify them.
  assign cmd_d_o  = {req_we_i, req_addr_i, (req_we_i ? req_data_i : 16'h0000)};
  assign bcmd_d_o = {8'h00, req_addr_i[23:3], 3'b000};

  // Response presentation: only the FIFO named by the tag head may answer,
  // which enforces issue order even when burst data arrives early.
  assign rsp_valid_o      = (state_reg == IDLE) && !tag_empty &&
                            (tag_head ? !rdb_empty_i : !rd_empty_i);
  assign rsp_burst_o      = tag_head;
  assign rsp_data_o       = rd_q_i;
  assign rsp_burst_data_o = rdb_q_i;

  assign tag_pop   = rsp_valid_o && rsp_ready_i;
  assign rd_deq_o  = tag_pop && !tag_head;
  assign rdb_deq_o = tag_pop && tag_head;

  // Tag storage: one bit per outstanding read (1 = burst).
  always_ff @(posedge clk) begin
    if (tag_push)
      tag_mem[wr_ptr_reg[TAG_AW-1:0]] <= req_burst_i;
  end

  // Tag pointers; push and pop in the same cycle leave occupancy unchanged.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (tag_push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (tag_pop)
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Response FSM: a GAP cycle after each pop lets the FIFO empty flag settle.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_reg <= IDLE;
    end else begin
      case (state_reg)
        IDLE:    if (tag_pop) state_reg <= GAP;
        GAP:     state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Sticky error: data present with no outstanding tag for two cycles running.
  assign stray_data = (!rd_empty_i || !rdb_empty_i) && tag_empty;

  always_ff @(posedge clk) begin
    if (rst_i) begin
      err_pend_reg <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      err_pend_reg <= stray_data;
      if (stray_data && err_pend_reg)
        err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;

endmodule

// File: doc/sdram_client_port.md
Name: sdram_client_port

Overview:
- User-side requester for the SDRAM command/data FIFO interface. It turns a valid/ready request bus into single-word command enqueues (41-bit) and burst-read command enqueues (32-bit).
- It dequeues returned data from the single-word (16-bit) and burst (128-bit) read-data FIFOs. Responses are delivered strictly in request-issue order, even though the controller serves burst reads ahead of single commands.
- It sits in the user clock domain, which drives both the writer and reader sides of the SDRAM controller.

Parameters:
TAG_AW, 4, log2 of read-tag FIFO depth; at most 2**TAG_AW reads outstanding.

Ports:
clk  in  1  user clock; also drives the controller writer_clk and reader_clk.
rst_i  in  1  synchronous reset, active-high; shared with the controller writer/reader resets.
req_valid_i  in  1  request valid.
req_ready_o  out  1  request accepted when valid & ready.
req_we_i  in  1  1 = single-word write, 0 = read.
req_burst_i  in  1  read only: 1 = 8-word burst read; ignored when req_we_i=1.
req_addr_i  in  24  word address.
req_data_i  in  16  write data.
rsp_valid_o  out  1  response valid.
rsp_ready_i  in  1  response consumed when valid & ready.
rsp_burst_o  out  1  1 = rsp_burst_data_o is valid, 0 = rsp_data_o is valid.
rsp_data_o  out  16  single-word read data.
rsp_burst_data_o  out  128  burst data; word 0 in [127:112], word 7 in [15:0].
err_o  out  1  sticky: read data arrived with no matching outstanding tag.
cmd_d_o  out  41  {we, addr[23:0], data[15:0]}.
cmd_enq_o  out  1  single-command enqueue.
cmd_full_i  in  1  single-command FIFO full.
bcmd_d_o  out  32  {8'b0, addr[23:3], 3'b000}.
bcmd_enq_o  out  1  burst-command enqueue.
bcmd_full_i  in  1  burst-command FIFO full.
rd_q_i  in  16  single-data FIFO head (first-word fall-through).
rd_empty_i  in  1  single-data FIFO empty.
rd_deq_o  out  1  single-data FIFO dequeue.
rdb_q_i  in  128  burst-data FIFO head (first-word fall-through).
rdb_empty_i  in  1  burst-data FIFO empty.
rdb_deq_o  out  1  burst-data FIFO dequeue.

Behaviour:
- Request side (combinational, zero latency):
  - Write: req_ready_o = !cmd_full_i.
  - Single read: req_ready_o = !cmd_full_i & !tag_full.
  - Burst read: req_ready_o = !bcmd_full_i & !tag_full.
- Enqueue on accept:
  - cmd_enq_o = accept & !burst-read; cmd_d_o = {req_we_i, req_addr_i, req_we_i ? req_data_i : 16'h0}.
  - bcmd_enq_o = accept & burst-read; req_addr_i[2:0] is forced to 0.
  - cmd_d_o and bcmd_d_o are driven from the request inputs at all times; only the enq strobes qualify them.
- Tag FIFO:
  - 1-bit entries (1 = burst), depth 2**TAG_AW; a tag is pushed on every accepted read. Writes push no tag and produce no response.
  - tag_full is derived from a TAG_AW+1-bit pointer difference.
- Response FSM states:
  - IDLE: rsp_valid_o = tag_nonempty & (head ? !rdb_empty_i : !rd_empty_i). rsp_burst_o = tag head. rsp_data_o = rd_q_i; rsp_burst_data_o = rdb_q_i.
    - On valid & ready: pulse the matching deq for exactly 1 cycle, pop the tag, go to GAP.
  - GAP: rsp_valid_o = 0 for 1 cycle so the FIFO empty flag can update; then return to IDLE. Maximum throughput is 1 response per 2 cycles.
- Ordering: responses follow request-issue order. Example: tag head = single while burst data is already present → the burst data is held until the single data arrives. No ordering is guaranteed between a single write and a later burst read to the same address; the user must wait for an intervening single-read response as a fence.
- Simultaneous read accept and response pop: the tag FIFO pushes and pops in the same cycle; occupancy is unchanged.
- Error detection: err_o is set when (!rd_empty_i or !rdb_empty_i) while the tag FIFO is empty for 2 consecutive cycles. It is cleared only by reset.
- Reset values: tag FIFO empty, FSM = IDLE, err_o = 0, rsp_valid_o = 0, cmd_enq_o = bcmd_enq_o = rd_deq_o = rdb_deq_o = 0.
- Reset mid-operation discards all tags. rst_i must also reset the controller FIFOs; otherwise stale data sets err_o.

Test Plan:
- Write addr 0x000123, data 0xBEEF; then single read of 0x000123. Required: cmd_d_o = {1,0x000123,0xBEEF} on the write; one cmd_enq_o pulse with bit40 = 0 on the read; model returns 0xBEEF → rsp_valid_o with rsp_burst_o = 0 and rsp_data_o = 0xBEEF; rd_deq_o is a single-cycle pulse.
- Burst read at addr 0x000105 → bcmd_d_o = 0x00000100. Model returns words 0x1111..0x8888 → rsp_burst_data_o = 0x1111_2222_..._8888, rsp_burst_o = 1.
- Single read A, then burst read B; the model fills the burst FIFO first and the single FIFO 10 cycles later. Required: no rsp_valid_o until the single data is present; the single response comes first, then the burst response after the GAP cycle.
- TAG_AW = 2: issue 4 reads with no data returned → 5th read sees req_ready_o = 0, while a write in the same state is accepted. After one response pops, the read is accepted.
- cmd_full_i = 1 → write/single read stalled (ready 0, no enq); a burst read is still accepted. bcmd_full_i = 1 → the converse.
- rd_empty_i = 0 with no outstanding read for 2 cycles → err_o = 1 and stays 1 until rst_i; no rsp_valid_o is generated.
